alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-requester arbiter and sequencer for the single-cycle core's shared `ALU` instance. Each requester is either the main datapath or the branch/address unit. The block accepts operand/opcode transactions over a valid/ready handshake and grants them round-robin on contention. It registers the granted operands, evaluates them on one `ALU` instance, and returns result, flags and requester ID on a shared response channel with back-pressure. Only one transaction is in flight at a time; sustained throughput is one operation per cycle while `rsp_ready` stays high.

## Interface
Parameters:
- `LENGTH`, 32: operand and result width, passed to `ALU`.
- `CTRL_W`, 5: opcode width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req0_valid`, `req1_valid`  in  1  requester i presents a transaction.
- `req0_ready`, `req1_ready`  out  1  the transaction of requester i is accepted this cycle.
- `req0_a`, `req1_a`  in  LENGTH  operand A, signed.
- `req0_b`, `req1_b`  in  LENGTH  operand B, signed.
- `req0_ctrl`, `req1_ctrl`  in  CTRL_W  `ALU` opcode.
- `rsp_valid`  out  1  a response is presented.
- `rsp_ready`  in  1  the consumer takes the response this cycle.
- `rsp_id`  out  1  index of the requester that owns the response.
- `rsp_result`  out  LENGTH  `ALU` result for the latched operands.
- `rsp_zero`  out  1  `ALU` zero flag.
- `rsp_neg`  out  1  `ALU` negative flag, equal to result MSB.
- `rsp_illegal`  out  1  latched opcode is not in the legal set; the result is 0.

## Operation
- State machine with two states:
  - IDLE: no response held.
  - RESP: operands, opcode and ID are latched in registers `a_q`, `b_q`, `ctrl_q`, `id_q`; `rsp_valid`=1.
- `can_accept` = (state==IDLE) | (state==RESP & rsp_ready).
- Grant rule:
  - If only one `reqi_valid` is high, that requester wins.
  - If both are high, the requester opposite to `last_q` wins.
- `reqi_ready` = `can_accept` & requester i wins. It is 0 for the losing requester.
- Accept (valid & ready on port i):
  - Latch `reqi_a`, `reqi_b`, `reqi_ctrl` and `id_q`=i.
  - Set `last_q`=i.
  - Next state RESP.
- State transitions:
  - RESP with `rsp_ready`=1 and no accept: next state IDLE.
  - RESP with `rsp_ready`=0: hold all latched state. Both `reqi_ready` are 0.
- `ALU` is driven only from `a_q`/`b_q`/`ctrl_q`. `rsp_result`, `rsp_zero` and `rsp_neg` are the `ALU` outputs passed through combinationally.
- `rsp_illegal` = `ctrl_q` not in {00000, 01000, 00111, 00110, 00100, 00001, 00101, 01101, 00010, 00011, 10000}.
- Arithmetic and width rules are those of `ALU`: wrap-around add/sub/mul at LENGTH bits; shift amount is `b_q[4:0]`.

## Timing
- Latency: a transaction accepted at edge N has `rsp_valid`=1 from cycle N+1. The response holds stable until the cycle `rsp_ready`=1.
- Back-to-back: an accept in the same cycle as `rsp_ready`=1 loads the next transaction. `rsp_valid` stays 1 with new contents, with no bubble.
- Combinational paths:
  - `reqi_ready` depends on `rsp_ready` and on both `reqi_valid`.
  - No path runs from `reqi_a`/`reqi_b`/`reqi_ctrl` to any output.
- Reset values:
  - state=IDLE, so `rsp_valid`=0.
  - `last_q`=1, so port 0 wins the first tie.
  - `a_q`=`b_q`=0, `ctrl_q`=00000, `id_q`=0.
  - Resulting outputs: `rsp_result`=0, `rsp_zero`=1, `rsp_neg`=0, `rsp_illegal`=0, `rsp_id`=0.
- Reset mid-operation: the in-flight response is discarded with no handshake, and `rsp_valid`=0 the cycle after reset is sampled.
- While `reset`=1, both `reqi_ready`=0.
- A requester that drops valid while not ready loses no state. Nothing is latched until the accept.

## Structure
- Package `alu_arbiter_pkg`:
  - `localparam`s for the 11 `ALU` opcodes (`ALU_ADD`=00000 … `ALU_MUL`=10000).
  - Function `is_legal_op`.
  - Enum `arb_state_t` {IDLE, RESP}.
- One sub-module: the existing `ALU` (LENGTH passed through), instantiated once.
- Grant logic, state and operand registers stay in the top module.

## Test plan
- After reset: `rsp_valid`=0, `rsp_zero`=1, `req0_ready`=1 when only req0 is valid.
- Single add: req0 with a=5, b=3, ctrl=00000 → next cycle `rsp_valid`=1, `rsp_id`=0, result=8, zero=0, neg=0.
- Tie and round-robin:
  - Both requesters valid continuously from reset: req0 is accepted first, then req1, then req0 again.
  - With `rsp_ready`=1 the ready pulses alternate ports and give one response per cycle.
- Back-pressure: req1 with a=3, b=5, ctrl=01000; hold `rsp_ready`=0 for 4 cycles.
  - Result 0xFFFFFFFE, neg=1, stable all 4 cycles.
  - Both readies are 0 throughout.
  - On release, a pending req0 is accepted in the same cycle.
- Illegal opcode: ctrl=11111 → result=0, zero=1, `rsp_illegal`=1.
- Reset mid-operation: assert `reset` while `rsp_valid`=1 and `rsp_ready`=0 → `rsp_valid`=0 next cycle; the first tie after reset grants port 0.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter_pkg
//  Description : Shared opcodes, opcode legality check and arbiter state
//                encoding for the alu_arbiter block.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_arbiter_pkg;

    // ALU opcode set (bit 3 selects the subtract/arithmetic variant)
    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b01000;
    localparam logic [4:0] ALU_AND  = 5'b00111;
    localparam logic [4:0] ALU_OR   = 5'b00110;
    localparam logic [4:0] ALU_XOR  = 5'b00100;
    localparam logic [4:0] ALU_SLL  = 5'b00001;
    localparam logic [4:0] ALU_SRL  = 5'b00101;
    localparam logic [4:0] ALU_SRA  = 5'b01101;
    localparam logic [4:0] ALU_SLT  = 5'b00010;
    localparam logic [4:0] ALU_SLTU = 5'b00011;
    localparam logic [4:0] ALU_MUL  = 5'b10000;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } arb_state_t;

    function automatic logic is_legal_op(input logic [4:0] op);
        case (op)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL,
            ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_MUL: return 1'b1;
            default:                                      return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_alu.sv
`default_nettype none
// ============================================================================
//  Module      : ALU
//  Description : Combinational LENGTH-bit ALU. Illegal opcodes yield 0.
//                Add/sub/mul wrap at LENGTH bits; shifts use b[4:0].
//  Revision    : 1.0 - initial release
// ============================================================================
module ALU
    import alu_arbiter_pkg::*;
#(
    parameter int LENGTH = 32
) (
    input  logic [LENGTH-1:0] i_a,
    input  logic [LENGTH-1:0] i_b,
    input  logic [4:0]        i_ctrl,
    output logic [LENGTH-1:0] o_result,
    output logic              o_zero,
    output logic              o_neg
);

    logic [LENGTH-1:0] w_result;

    // Opcode decode; anything outside the legal set falls to zero
    always_comb begin
        w_result = '0;
        case (i_ctrl)
            ALU_ADD:  w_result = i_a + i_b;
            ALU_SUB:  w_result = i_a - i_b;
            ALU_AND:  w_result = i_a & i_b;
            ALU_OR:   w_result = i_a | i_b;
            ALU_XOR:  w_result = i_a ^ i_b;
            ALU_SLL:  w_result = i_a << i_b[4:0];
            ALU_SRL:  w_result = i_a >> i_b[4:0];
            ALU_SRA:  w_result = $unsigned($signed(i_a) >>> i_b[4:0]);
            ALU_SLT:  w_result = {{(LENGTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            ALU_SLTU: w_result = {{(LENGTH-1){1'b0}}, (i_a < i_b)};
            ALU_MUL:  w_result = i_a * i_b;
            default:  w_result = '0;
        endcase
    end

    assign o_result = w_result;
    assign o_zero   = (w_result == '0);
    assign o_neg    = w_result[LENGTH-1];

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Round-robin arbiter for two requesters sharing one ALU.
//                One transaction in flight; response held until consumed,
//                with back-to-back accept on the consuming cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int LENGTH = 32,
    parameter int CTRL_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [LENGTH-1:0] req0_a,
    input  logic [LENGTH-1:0] req0_b,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [LENGTH-1:0] req1_a,
    input  logic [LENGTH-1:0] req1_b,
    input  logic [CTRL_W-1:0] req1_ctrl,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [LENGTH-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_neg,
    output logic              rsp_illegal
);

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    logic              r_last;
    logic [LENGTH-1:0] r_a;
    logic [LENGTH-1:0] r_b;
    logic [CTRL_W-1:0] r_ctrl;
    logic              r_id;

    logic              w_can_accept;
    logic              w_win0;
    logic              w_win1;
    logic              w_acc0;
    logic              w_acc1;
    logic              w_acc;
    logic              w_ctrl_hi_zero;
    logic              w_legal;
    logic [4:0]        w_alu_ctrl;

    // Accept when empty, or when the held response leaves this cycle
    assign w_can_accept = (r_state == IDLE) || ((r_state == RESP) && rsp_ready);

    // On a tie the port that did not win last time is favoured
    assign w_win0 = req0_valid && (!req1_valid || r_last);
    assign w_win1 = req1_valid && (!req0_valid || !r_last);

    assign req0_ready = !reset && w_can_accept && w_win0;
    assign req1_ready = !reset && w_can_accept && w_win1;

    assign w_acc0 = req0_valid && req0_ready;
    assign w_acc1 = req1_valid && req1_ready;
    assign w_acc  = w_acc0 || w_acc1;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: load on accept, drain on consume, otherwise hold
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_acc) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                if (rsp_ready && !w_acc) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Operand, opcode, owner and round-robin pointer capture on accept
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a    <= '0;
            r_b    <= '0;
            r_ctrl <= '0;
            r_id   <= 1'b0;
            r_last <= 1'b1;
        end else if (w_acc0) begin
            r_a    <= req0_a;
            r_b    <= req0_b;
            r_ctrl <= req0_ctrl;
            r_id   <= 1'b0;
            r_last <= 1'b0;
        end else if (w_acc1) begin
            r_a    <= req1_a;
            r_b    <= req1_b;
            r_ctrl <= req1_ctrl;
            r_id   <= 1'b1;
            r_last <= 1'b1;
        end
    end

    // Opcode bits above the 5-bit ALU field must be zero to be legal
    if (CTRL_W > 5) begin : g_ctrl_wide
        assign w_ctrl_hi_zero = (r_ctrl[CTRL_W-1:5] == '0);
    end else begin : g_ctrl_narrow
        assign w_ctrl_hi_zero = 1'b1;
    end

    assign w_legal    = w_ctrl_hi_zero && is_legal_op(r_ctrl[4:0]);
    // Force a known-illegal code so the ALU returns 0 for any illegal opcode
    assign w_alu_ctrl = w_legal ? r_ctrl[4:0] : 5'b11111;

    ALU #(
        .LENGTH (LENGTH)
    ) u_alu (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_ctrl   (w_alu_ctrl),
        .o_result (rsp_result),
        .o_zero   (rsp_zero),
        .o_neg    (rsp_neg)
    );

    assign rsp_valid   = (r_state == RESP);
    assign rsp_id      = r_id;
    assign rsp_illegal = !w_legal;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_arbiter
//  Description : Self-checking bench for alu_arbiter: opcode vector table,
//                response scoreboard, round-robin, back-pressure and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [4:0]  req0_ctrl, req1_ctrl;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_zero, rsp_neg, rsp_illegal;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  ctrl;
        logic [31:0] res;
        logic        zero;
        logic        neg;
        logic        ill;
    } vec_t;

    typedef struct {
        logic        id;
        logic [31:0] res;
        logic        ill;
    } exp_t;

    vec_t vecs[18];
    exp_t sb_q[$];

    alu_arbiter #(.LENGTH(32), .CTRL_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_ctrl   (req0_ctrl),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_ctrl   (req1_ctrl),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
        .rsp_zero    (rsp_zero),
        .rsp_neg     (rsp_neg),
        .rsp_illegal (rsp_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Independent reference: {illegal, result}
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
        logic [31:0] r;
        logic        il;
        il = 1'b0;
        case (op)
            5'b00000: r = a + b;
            5'b01000: r = a - b;
            5'b00111: r = a & b;
            5'b00110: r = a | b;
            5'b00100: r = a ^ b;
            5'b00001: r = a << b[4:0];
            5'b00101: r = a >> b[4:0];
            5'b01101: r = $unsigned($signed(a) >>> b[4:0]);
            5'b00010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'b00011: r = (a < b) ? 32'd1 : 32'd0;
            5'b10000: r = a * b;
            default: begin r = 32'd0; il = 1'b1; end
        endcase
        return {il, r};
    endfunction

    // Scoreboard: push on accept, compare every presented response, pop on consume
    always @(negedge clk) begin
        if (reset) begin
            sb_q.delete();
        end else begin
            if (rsp_valid) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_rsp", 64'(rsp_valid), 64'd0);
                end else begin
                    chk("sb_rsp",
                        {rsp_id, rsp_illegal, rsp_neg, rsp_zero, rsp_result},
                        {sb_q[0].id, sb_q[0].ill, sb_q[0].res[31], (sb_q[0].res == 32'd0), sb_q[0].res});
                    if (rsp_ready) void'(sb_q.pop_front());
                end
            end
            if (req0_valid && req0_ready) begin
                logic [32:0] m;
                m = model(req0_a, req0_b, req0_ctrl);
                sb_q.push_back('{id: 1'b0, res: m[31:0], ill: m[32]});
            end
            if (req1_valid && req1_ready) begin
                logic [32:0] m;
                m = model(req1_a, req1_b, req1_ctrl);
                sb_q.push_back('{id: 1'b1, res: m[31:0], ill: m[32]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{32'd5,        32'd3,        5'b00000, 32'd8,        1'b0, 1'b0, 1'b0};
        vecs[1]  = '{32'd3,        32'd5,        5'b01000, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{32'hF0F01234, 32'h0FF0FF00, 5'b00111, 32'h00F01200, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{32'hF0000000, 32'h0000000F, 5'b00110, 32'hF000000F, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{32'hFFFF0000, 32'hFF00FF00, 5'b00100, 32'h00FFFF00, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{32'd1,        32'd31,       5'b00001, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{32'd1,        32'h21,       5'b00001, 32'd2,        1'b0, 1'b0, 1'b0};
        vecs[7]  = '{32'h80000000, 32'd4,        5'b00101, 32'h08000000, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{32'h80000000, 32'd4,        5'b01101, 32'hF8000000, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{32'h80000000, 32'h3F,       5'b01101, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{32'hFFFFFFFF, 32'd1,        5'b00010, 32'd1,        1'b0, 1'b0, 1'b0};
        vecs[11] = '{32'hFFFFFFFF, 32'd1,        5'b00011, 32'd0,        1'b1, 1'b0, 1'b0};
        vecs[12] = '{32'h00010000, 32'h00010000, 5'b10000, 32'd0,        1'b1, 1'b0, 1'b0};
        vecs[13] = '{32'hFFFFFFFD, 32'd7,        5'b10000, 32'hFFFFFFEB, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{32'h7FFFFFFF, 32'd1,        5'b00000, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{32'd1,        32'hFFFFFFFF, 5'b00000, 32'd0,        1'b1, 1'b0, 1'b0};
        vecs[16] = '{32'd5,        32'd3,        5'b11111, 32'd0,        1'b1, 1'b0, 1'b1};
        vecs[17] = '{32'd5,        32'd3,        5'b01001, 32'd0,        1'b1, 1'b0, 1'b1};

        reset = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_ctrl = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_ctrl = '0;

        // Reset state and readiness
        step(); step();
        chk("rst_hold_rdy0", 64'(req0_ready), 64'd0);
        step();
        reset = 1'b0; req0_valid = 1'b0;
        #1;
        chk("rst_rsp_valid",   64'(rsp_valid),   64'd0);
        chk("rst_rsp_result",  64'(rsp_result),  64'd0);
        chk("rst_rsp_zero",    64'(rsp_zero),    64'd1);
        chk("rst_rsp_neg",     64'(rsp_neg),     64'd0);
        chk("rst_rsp_illegal", 64'(rsp_illegal), 64'd0);
        chk("rst_rsp_id",      64'(rsp_id),      64'd0);
        req0_valid = 1'b1;
        #1;
        chk("rst_rdy0_single", 64'(req0_ready), 64'd1);
        chk("rst_rdy1_single", 64'(req1_ready), 64'd0);
        req0_valid = 1'b0;

        // Opcode table, alternating ports, back-to-back with rsp_ready high
        rsp_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            if (i % 2 == 0) begin
                req0_valid = 1'b1; req0_a = vecs[i].a; req0_b = vecs[i].b; req0_ctrl = vecs[i].ctrl;
            end else begin
                req1_valid = 1'b1; req1_a = vecs[i].a; req1_b = vecs[i].b; req1_ctrl = vecs[i].ctrl;
            end
            step();
            req0_valid = 1'b0; req1_valid = 1'b0;
            #1;
            chk($sformatf("vec%0d_valid", i),  64'(rsp_valid),   64'd1);
            chk($sformatf("vec%0d_id", i),     64'(rsp_id),      64'(i % 2));
            chk($sformatf("vec%0d_result", i), 64'(rsp_result),  64'(vecs[i].res));
            chk($sformatf("vec%0d_flags", i),  {rsp_zero, rsp_neg, rsp_illegal},
                {vecs[i].zero, vecs[i].neg, vecs[i].ill});
        end
        step();
        chk("table_drained", 64'(rsp_valid), 64'd0);

        // Tie from reset: grants alternate 0,1,0,... with one response per cycle
        reset = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd100; req0_b = 32'd23; req0_ctrl = 5'b00000;
        req1_valid = 1'b1; req1_a = 32'd6;   req1_b = 32'd7;  req1_ctrl = 5'b10000;
        step(); step();
        #1;
        chk("rr_rst_rdy0", 64'(req0_ready), 64'd0);
        chk("rr_rst_rdy1", 64'(req1_ready), 64'd0);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("rr%0d_rdy0", k), 64'(req0_ready), 64'(k % 2 == 0));
            chk($sformatf("rr%0d_rdy1", k), 64'(req1_ready), 64'(k % 2 == 1));
            if (k > 0) begin
                chk($sformatf("rr%0d_rsp_valid", k), 64'(rsp_valid), 64'd1);
                chk($sformatf("rr%0d_rsp_id", k),    64'(rsp_id),    64'((k - 1) % 2));
            end
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        chk("rr_last_id", 64'(rsp_id), 64'd1);
        step();

        // Back-pressure: SUB on port 1 held while port 0 waits
        req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd5; req1_ctrl = 5'b01000;
        step();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd20; req0_ctrl = 5'b00000;
        rsp_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("bp%0d_result", c), 64'(rsp_result), 64'hFFFFFFFE);
            chk($sformatf("bp%0d_neg", c),    64'(rsp_neg),    64'd1);
            chk($sformatf("bp%0d_id", c),     64'(rsp_id),     64'd1);
            chk($sformatf("bp%0d_rdys", c),   64'({req0_ready, req1_ready}), 64'd0);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_rdy0", 64'(req0_ready), 64'd1);
        step();
        req0_valid = 1'b0;
        #1;
        chk("bp_next_valid",  64'(rsp_valid),  64'd1);
        chk("bp_next_id",     64'(rsp_id),     64'd0);
        chk("bp_next_result", 64'(rsp_result), 64'd30);
        step();

        // Reset mid-operation with a stalled response; tie then goes to port 0
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_ctrl = 5'b00000;
        rsp_ready = 1'b0;
        step();
        req0_valid = 1'b0;
        #1;
        chk("mid_valid_before", 64'(rsp_valid), 64'd1);
        reset = 1'b1;
        step();
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("mid_valid_after", 64'(rsp_valid), 64'd0);
        chk("mid_rst_rdys",    64'({req0_ready, req1_ready}), 64'd0);
        reset = 1'b0; rsp_ready = 1'b1;
        #1;
        chk("mid_tie_rdy0", 64'(req0_ready), 64'd1);
        chk("mid_tie_rdy1", 64'(req1_ready), 64'd0);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        chk("mid_tie_rsp_id", 64'(rsp_id), 64'd0);
        step(); step();
        chk("sb_drain", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
